// File: rtl/mpsub_ctrl.sv
// Byte-serial multi-precision subtract sequencer for an external 8-bit subtractor
// with no borrow-in; a pending borrow costs one extra FIX pass per byte.
module mpsub_ctrl #(
  parameter int BYTES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8*BYTES-1:0] op_a,
  input  logic [8*BYTES-1:0] op_b,
  output logic               ready,
  output logic               done,
  output logic [8*BYTES-1:0] result,
  output logic               flag_z,
  output logic               flag_c,
  output logic               flag_n,
  output logic               flag_v,
  output logic [7:0]         sub_a,
  output logic [7:0]         sub_b,
  input  logic [7:0]         sub_diff,
  input  logic               sub_bout
);

  localparam int W  = 8 * BYTES;
  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, work_q, result_q;
  logic [IW-1:0]   idx_q;
  logic            borrow_q, b1_q;
  logic [7:0]      tmp_q;
  logic            ready_q, done_q;
  logic            fz_q, fc_q, fn_q, fv_q;

  logic [7:0]      a_byte, b_byte;
  logic [W-1:0]    res_d;
  logic            borrow_d, last;

  always_comb begin
    a_byte = 8'h00;
    b_byte = 8'h00;
    res_d  = work_q;
    for (int i = 0; i < BYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte           = a_q[i*8 +: 8];
        b_byte           = b_q[i*8 +: 8];
        res_d[i*8 +: 8]  = sub_diff;
      end
    end
    last     = (idx_q == IW'(BYTES - 1));
    borrow_d = (state_q == FIX) ? (b1_q | sub_bout) : sub_bout;
    sub_a    = 8'h00;
    sub_b    = 8'h00;
    case (state_q)
      SUB: begin
        sub_a = a_byte;
        sub_b = b_byte;
      end
      FIX: begin
        sub_a = tmp_q;
        sub_b = 8'h01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      b1_q     <= 1'b0;
      tmp_q    <= 8'h00;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fn_q     <= 1'b0;
      fv_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= op_a;
            b_q      <= op_b;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            work_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
            state_q  <= SUB;
          end
        end
        SUB, FIX: begin
          if (state_q == SUB && borrow_q) begin
            // first pass of a borrowed byte; FIX subtracts the pending 1
            tmp_q   <= sub_diff;
            b1_q    <= sub_bout;
            state_q <= FIX;
          end else begin
            work_q   <= res_d;
            borrow_q <= borrow_d;
            if (last) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= res_d;
              fz_q     <= (res_d == '0);
              fc_q     <= borrow_d;
              fn_q     <= res_d[W-1];
              fv_q     <= (a_q[W-1] ^ b_q[W-1]) & (a_q[W-1] ^ res_d[W-1]);
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= SUB;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_n = fn_q;
  assign flag_v = fv_q;

endmodule

// File: tb/tb_mpsub_ctrl.sv
// Directed bench for mpsub_ctrl (BYTES=2) with a behavioural 8-bit subtractor attached.
module tb_mpsub_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] op_a, op_b;
  logic        ready, done;
  logic [15:0] result;
  logic        flag_z, flag_c, flag_n, flag_v;
  logic [7:0]  sub_a, sub_b, sub_diff;
  logic        sub_bout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb {sub_bout, sub_diff} = {1'b0, sub_a} - {1'b0, sub_b};

  mpsub_ctrl #(.BYTES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .ready(ready), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v),
    .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_bout(sub_bout)
  );

  // Drive one op and wait for done; lat counts rising edges from start to done.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output int lat, output bit to);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    lat   = 0;
    to    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 16'h0;
    op_b  = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL reset_rd ready/done got=%b exp=10", {ready, done});
    end
    total++;
    if ({result, flag_z, flag_c, flag_n, flag_v} !== 20'h0) begin
      bad++; $display("FAIL reset_res result=%h flags=%b exp 0", result, {flag_z, flag_c, flag_n, flag_v});
    end
    total++;
    if ({sub_a, sub_b} !== 16'h0) begin
      bad++; $display("FAIL reset_sub got=%h exp=0000", {sub_a, sub_b});
    end
  endtask

  task automatic test_basic;
    int lat; bit to;
    do_op(16'h1234, 16'h0234, lat, to);
    total++;
    if (to || lat != 3) begin
      bad++; $display("FAIL basic_lat got=%0d exp=3 timeout=%0d", lat, to);
    end
    total++;
    if ({result, flag_z, flag_c, flag_n, flag_v} !== {16'h1000, 4'b0000}) begin
      bad++; $display("FAIL basic_res got=%h/%b exp=1000/0000", result, {flag_z, flag_c, flag_n, flag_v});
    end
    @(negedge clk);
    total++;
    if ({ready, done} !== 2'b10) begin
      bad++; $display("FAIL basic_idle ready/done got=%b exp=10", {ready, done});
    end
  endtask

  task automatic test_fix;
    logic [15:0] seq [3];
    bit ok;
    seq[0] = 16'h0001;
    seq[1] = 16'h1200;
    seq[2] = 16'h1201;
    @(negedge clk);
    op_a = 16'h1200; op_b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({sub_a, sub_b} !== seq[i] || done !== 1'b0) begin
        bad++; $display("FAIL fix_seq%0d sub=%h done=%b exp=%h/0", i, {sub_a, sub_b}, done, seq[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL fix_lat done=%b exp=1 at edge 4", done);
    end
    total++;
    if ({result, flag_z, flag_c, flag_n, flag_v} !== {16'h11FF, 4'b0000}) begin
      bad++; $display("FAIL fix_res got=%h/%b exp=11ff/0000", result, {flag_z, flag_c, flag_n, flag_v});
    end
    ok = 1'b1;
  endtask

  task automatic test_wrap;
    int lat; bit to;
    do_op(16'h0000, 16'h0001, lat, to);
    total++;
    if (to || lat != 4 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'hFFFF, 4'b0110}) begin
      bad++; $display("FAIL wrap_neg got=%h/%b lat=%0d exp=ffff/0110 lat=4", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
    do_op(16'hABCD, 16'hABCD, lat, to);
    total++;
    if (to || lat != 3 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'h0000, 4'b1000}) begin
      bad++; $display("FAIL wrap_zero got=%h/%b lat=%0d exp=0000/1000 lat=3", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
  endtask

  task automatic test_overflow;
    int lat; bit to;
    do_op(16'h8000, 16'h0001, lat, to);
    total++;
    if (to || lat != 4 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'h7FFF, 4'b0001}) begin
      bad++; $display("FAIL ovf_pos got=%h/%b lat=%0d exp=7fff/0001 lat=4", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
    do_op(16'h7FFF, 16'hFFFF, lat, to);
    total++;
    if (to || lat != 3 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'h8000, 4'b0111}) begin
      bad++; $display("FAIL ovf_neg got=%h/%b lat=%0d exp=8000/0111 lat=3", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
  endtask

  task automatic test_busy;
    bit seen;
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h0234; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || result !== 16'h0000) begin
      bad++; $display("FAIL busy_clr ready=%b result=%h exp=0/0000", ready, result);
    end
    op_a = 16'hFFFF; op_b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else @(posedge clk);
    end
    total++;
    if (!seen || result !== 16'h1000 || flag_c !== 1'b0) begin
      bad++; $display("FAIL busy_res done_seen=%0d got=%h c=%b exp=1000 c=0", seen, result, flag_c);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (seen || ready !== 1'b1) begin
      bad++; $display("FAIL busy_noqueue extra_done=%0d ready=%b exp=0/1", seen, ready);
    end
  endtask

  task automatic test_back_to_back;
    int lat; bit to;
    do_op(16'h0005, 16'h0003, lat, to);
    total++;
    if (to || result !== 16'h0002) begin
      bad++; $display("FAIL b2b_first got=%h exp=0002 timeout=%0d", result, to);
    end
    do_op(16'h0100, 16'h0001, lat, to);
    total++;
    if (to || lat != 4 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'h00FF, 4'b0000}) begin
      bad++; $display("FAIL b2b_second got=%h/%b lat=%0d exp=00ff/0000 lat=4", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
  endtask

  task automatic test_reset_mid;
    int lat; bit to, seen;
    do_op(16'h0000, 16'h0001, lat, to);
    @(negedge clk);
    op_a = 16'h1200; op_b = 16'h0001; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (sub_b !== 8'h01 || sub_a !== 8'h12) begin
      bad++; $display("FAIL rstmid_fix sub=%h exp=1201", {sub_a, sub_b});
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || done !== 1'b0 ||
        {result, flag_z, flag_c, flag_n, flag_v} !== 20'h0) begin
      bad++; $display("FAIL rstmid_state ready=%b done=%b res=%h flags=%b exp=1/0/0000/0000",
                      ready, done, result, {flag_z, flag_c, flag_n, flag_v});
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++; $display("FAIL rstmid_nodone got done=1 exp none");
    end
    do_op(16'h0000, 16'h0001, lat, to);
    total++;
    if (to || lat != 4 || {result, flag_z, flag_c, flag_n, flag_v} !== {16'hFFFF, 4'b0110}) begin
      bad++; $display("FAIL rstmid_after got=%h/%b lat=%0d exp=ffff/0110 lat=4", result, {flag_z, flag_c, flag_n, flag_v}, lat);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fix;
    test_wrap;
    test_overflow;
    test_busy;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
